// File: rtl/cfg_pkg.sv
// Shared configuration constants and types for the bitstream loader and the
// fabric-side GlobalFSM, which must agree on the frame width.
package cfg_pkg;

  localparam int FRAME_W         = 77;
  localparam int NUM_FRAMES      = 16;
  localparam int BYTES_PER_FRAME = (FRAME_W + 7) / 8;

  localparam int FCNT_W    = $clog2(NUM_FRAMES + 1);
  localparam int BCNT_W    = $clog2(BYTES_PER_FRAME);
  // Number of payload bits carried by the final byte of a frame
  localparam int LAST_BITS = FRAME_W - 8 * (BYTES_PER_FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SEND,
    S_WAIT_DONE,
    S_DONE,
    S_ERROR
  } loader_state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_PAD     = 2'd1;
  localparam err_code_t ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/frame_packer.sv
// Packs host bytes into one FRAME_W-bit frame, checks the padding bits of the
// final byte, and holds the finished frame until the fabric takes it.
module frame_packer
  import cfg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               collect_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_v_i,
  output logic               byte_r_o,
  input  logic               frame_taken_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               frame_valid_o,
  output logic               frame_done_o,
  output logic               pad_err_o
);

  logic [BCNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               full_q, full_d;
  logic               byte_fire;
  logic               last_byte;

  assign byte_r_o      = collect_i && !full_q;
  assign byte_fire     = byte_v_i && byte_r_o;
  assign last_byte     = byte_fire && (byte_cnt_q == BCNT_W'(BYTES_PER_FRAME - 1));
  // Bits of the last byte beyond the frame width must be zero
  assign pad_err_o     = last_byte && (byte_i[7:LAST_BITS] != '0);
  assign frame_done_o  = last_byte && !pad_err_o;
  assign frame_o       = frame_q;
  assign frame_valid_o = full_q;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    frame_d    = frame_q;
    full_d     = full_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      full_d     = 1'b0;
    end else begin
      if (byte_fire) begin
        if (last_byte) begin
          frame_d[FRAME_W-1 -: LAST_BITS] = byte_i[LAST_BITS-1:0];
          byte_cnt_d = '0;
          full_d     = !pad_err_o;
        end else begin
          for (int k = 0; k < BYTES_PER_FRAME - 1; k++) begin
            if (byte_cnt_q == BCNT_W'(k)) begin
              frame_d[8*k +: 8] = byte_i;
            end
          end
          byte_cnt_d = byte_cnt_q + BCNT_W'(1);
        end
      end
      if (frame_taken_i) begin
        full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      frame_q    <= '0;
      full_q     <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      frame_q    <= frame_d;
      full_q     <= full_d;
    end
  end

endmodule

// File: rtl/bitstream_loader.sv
// Host-side bitstream source: collects bytes into frames, streams NUM_FRAMES
// frames to the fabric, then waits for the fabric's done with a timeout.
module bitstream_loader
  import cfg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_v_i,
  output logic               byte_r_o,
  output logic [FRAME_W-1:0] bit_o,
  output logic               bit_v_o,
  input  logic               bit_r_i,
  input  logic               done_i,
  output logic               busy_o,
  output logic               cfg_done_o,
  output logic               err_o,
  output logic [1:0]         err_code_o,
  output logic [FCNT_W-1:0]  frames_sent_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  loader_state_t     state_q, state_d;
  logic [FCNT_W-1:0] frames_q, frames_d;
  logic [FCNT_W-1:0] frames_inc;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  err_code_t         err_code_q, err_code_d;

  logic start_ok;
  logic frame_done;
  logic pad_err;
  logic frame_valid;
  logic frame_taken;

  frame_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (start_ok),
    .collect_i     (state_q == S_COLLECT),
    .byte_i        (byte_i),
    .byte_v_i      (byte_v_i),
    .byte_r_o      (byte_r_o),
    .frame_taken_i (frame_taken),
    .frame_o       (bit_o),
    .frame_valid_o (frame_valid),
    .frame_done_o  (frame_done),
    .pad_err_o     (pad_err)
  );

  // Valid comes only from the packer's holding register, never from bit_r_i
  assign bit_v_o     = frame_valid;
  assign frame_taken = frame_valid && bit_r_i;
  assign frames_inc  = frames_q + FCNT_W'(1);

  assign busy_o        = (state_q == S_COLLECT) || (state_q == S_SEND) ||
                         (state_q == S_WAIT_DONE);
  assign cfg_done_o    = (state_q == S_DONE);
  assign err_o         = (state_q == S_ERROR);
  assign err_code_o    = err_code_q;
  assign frames_sent_o = frames_q;

  always_comb begin
    state_d    = state_q;
    frames_d   = frames_q;
    tmo_d      = tmo_q;
    err_code_d = err_code_q;
    start_ok   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d    = S_COLLECT;
          frames_d   = '0;
          tmo_d      = '0;
          err_code_d = ERR_NONE;
          start_ok   = 1'b1;
        end
      end
      S_COLLECT: begin
        if (pad_err) begin
          state_d    = S_ERROR;
          err_code_d = ERR_PAD;
        end else if (frame_done) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (frame_taken) begin
          frames_d = frames_inc;
          if (frames_inc < FCNT_W'(NUM_FRAMES)) begin
            state_d = S_COLLECT;
          end else begin
            state_d = S_WAIT_DONE;
            tmo_d   = '0;
          end
        end
      end
      S_WAIT_DONE: begin
        // A done arriving on the final timeout cycle still wins
        if (done_i) begin
          state_d = S_DONE;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      frames_q   <= '0;
      tmo_q      <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      frames_q   <= frames_d;
      tmo_q      <= tmo_d;
      err_code_q <= err_code_d;
    end
  end

endmodule
